am_constants_load_ctrl: RTL and testbench

- Sequences loading of the AM modulation constants (carrier amplitude, depth, offset, gain) into the 2-stage 16-bit AM constants register path.
- The host writes a shadow bank at any time while idle, then requests a commit.
- The controller waits for a carrier sync strobe and streams the shadow words into the path, one per cycle.
- It emits an address/valid tag aligned with the path output, so the downstream AM multiplier sees a glitch-free update only at a carrier boundary.

---
 rtl/am_constants_load_ctrl.sv | 136 +++++++++++++
 tb/tb_am_constants_load_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/am_constants_load_ctrl.sv
// Sequences the shadow constant bank into the AM constants path at a carrier sync boundary.
// Optional macro AM_CONST_TIMEOUT_EN: ARMED gives up after TIMEOUT_CYC cycles and sets Timeout_Flag.
module am_constants_load_ctrl #(
   parameter int DW          = 16,
   parameter int NUM_CONST   = 4,
   parameter int AW          = 2,
   parameter int PIPE_LAT    = 2,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          Wr_En,
   input  logic [AW-1:0] Wr_Addr,
   input  logic [DW-1:0] Wr_Data,
   output logic          Wr_Ready,
   input  logic          Commit_Req,
   input  logic          Sync_Strobe,
   output logic [DW-1:0] Dout,
   output logic          Ld_Valid,
   output logic [AW-1:0] Ld_Addr,
   output logic          Vp_Valid,
   output logic [AW-1:0] Vp_Addr,
   output logic          Commit_Ack,
   output logic          Wr_Drop
`ifdef AM_CONST_TIMEOUT_EN
   ,
   output logic          Timeout_Flag
`endif
);

   typedef enum logic [1:0] {IDLE, ARMED, LOAD, DRAIN} state_t;

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int DRW = $clog2(PIPE_LAT + 1);
   localparam int CW = (TW > DRW) ? TW : DRW;

   state_t          state;
   logic [AW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   shadow [NUM_CONST];
   logic [PIPE_LAT-1:0] vp_valid_q;
   logic [AW-1:0]   vp_addr_q [PIPE_LAT];

   // Wr_Ready is registered, so it lags IDLE entry by one cycle; commit and
   // writes are only honoured once it is high.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         Wr_Ready   <= 1'b1;
         Dout       <= '0;
         Ld_Valid   <= 1'b0;
         Ld_Addr    <= '0;
         Commit_Ack <= 1'b0;
         Wr_Drop    <= 1'b0;
`ifdef AM_CONST_TIMEOUT_EN
         Timeout_Flag <= 1'b0;
`endif
         // NOTE: the shadow bank is reset because a commit straight after reset must load zeros.
         for (int i = 0; i < NUM_CONST; i++) shadow[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments everywhere here so every register samples pre-edge values.
         Commit_Ack <= 1'b0;
         if (Wr_En && !Wr_Ready) Wr_Drop <= 1'b1;
         case (state)
            IDLE: begin
               Wr_Ready <= 1'b1;
               if (Wr_Ready) begin
                  if (Wr_En) shadow[Wr_Addr] <= Wr_Data;
                  if (Commit_Req) begin
                     state    <= ARMED;
                     Wr_Ready <= 1'b0;
                     cnt      <= '0;
                  end
               end
            end
            ARMED: begin
               if (Sync_Strobe) begin
                  state <= LOAD;
                  idx   <= '0;
               end
`ifdef AM_CONST_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                  state        <= LOAD;
                  idx          <= '0;
                  Timeout_Flag <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            LOAD: begin
               Dout     <= shadow[idx];
               Ld_Valid <= 1'b1;
               Ld_Addr  <= idx;
               if (idx == AW'(NUM_CONST - 1)) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DRAIN: begin
               Ld_Valid <= 1'b0;
               if (cnt == CW'(PIPE_LAT - 1)) begin
                  state      <= IDLE;
                  Commit_Ack <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Free-running delay matching the external constants path.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         vp_valid_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) vp_addr_q[i] <= '0;
      end else begin
         vp_valid_q[0] <= Ld_Valid;
         vp_addr_q[0]  <= Ld_Addr;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vp_valid_q[i] <= vp_valid_q[i-1];
            vp_addr_q[i]  <= vp_addr_q[i-1];
         end
      end
   end

   assign Vp_Valid = vp_valid_q[PIPE_LAT-1];
   assign Vp_Addr  = vp_addr_q[PIPE_LAT-1];

endmodule

// File: tb/tb_am_constants_load_ctrl.sv
// Directed, table-driven bench for am_constants_load_ctrl at default parameters.
// With AM_CONST_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYC=8 and the timeout path is exercised.
module tb_am_constants_load_ctrl;

   typedef struct packed {
      logic        lv;
      logic [1:0]  la;
      logic [15:0] dout;
      logic        vv;
      logic [1:0]  va;
      logic        ack;
      logic        rdy;
      logic        drop;
   } obs_t;

   typedef struct {
      logic        we;
      logic [1:0]  wa;
      logic [15:0] wd;
      logic        cm;
      logic        st;
      obs_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        commit_req = 1'b0;
   logic        sync_strobe = 1'b0;
   logic        wr_ready, ld_valid, vp_valid, commit_ack, wr_drop;
   logic [15:0] dout;
   logic [1:0]  ld_addr, vp_addr;

   int tests = 0;
   int fails = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

`ifdef AM_CONST_TIMEOUT_EN
   logic timeout_flag;
   am_constants_load_ctrl #(.TIMEOUT_CYC(8)) dut (
`else
   am_constants_load_ctrl dut (
`endif
      .Clock(clk), .Reset_n(rst_n), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
      .Wr_Ready(wr_ready), .Commit_Req(commit_req), .Sync_Strobe(sync_strobe), .Dout(dout),
      .Ld_Valid(ld_valid), .Ld_Addr(ld_addr), .Vp_Valid(vp_valid), .Vp_Addr(vp_addr),
      .Commit_Ack(commit_ack), .Wr_Drop(wr_drop)
`ifdef AM_CONST_TIMEOUT_EN
      , .Timeout_Flag(timeout_flag)
`endif
   );

   function automatic obs_t o(input logic lv, input logic [1:0] la, input logic [15:0] d,
                              input logic vv, input logic [1:0] va, input logic ack,
                              input logic rdy, input logic drop);
      return '{lv, la, d, vv, va, ack, rdy, drop};
   endfunction

   function automatic obs_t sample();
      return '{ld_valid, ld_addr, dout, vp_valid, vp_addr, commit_ack, wr_ready, wr_drop};
   endfunction

   task automatic add(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                      input logic cm, input logic st, input obs_t e);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.st = st; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                        input logic cm, input logic st);
      wr_en = we; wr_addr = wa; wr_data = wd; commit_req = cm; sync_strobe = st;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      obs_t e;
      // Test 1: basic load, strobe 5 cycles after commit.
      add(1, 0, 16'h1111, 0, 0, o(0, 0, 16'h0000, 0, 0, 0, 1, 0));
      add(1, 1, 16'h2222, 0, 0, o(0, 0, 16'h0000, 0, 0, 0, 1, 0));
      add(1, 2, 16'h3333, 0, 0, o(0, 0, 16'h0000, 0, 0, 0, 1, 0));
      add(1, 3, 16'h4444, 0, 0, o(0, 0, 16'h0000, 0, 0, 0, 1, 0));
      add(0, 0, 16'h0000, 1, 0, o(0, 0, 16'h0000, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, o(0, 0, 16'h0000, 0, 0, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 1, o(0, 0, 16'h0000, 0, 0, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 0, o(1, 0, 16'h1111, 0, 0, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 0, o(1, 1, 16'h2222, 0, 0, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 0, o(1, 2, 16'h3333, 1, 0, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 0, o(1, 3, 16'h4444, 1, 1, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 1, 2, 0, 0, 0));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 1, 3, 1, 0, 0));
      add(0, 0, 16'h0000, 0, 1, o(0, 3, 16'h4444, 0, 3, 0, 1, 0));
      // Test 2: write during ARMED is dropped; Commit_Req during LOAD ignored.
      add(0, 0, 16'h0000, 1, 0, o(0, 3, 16'h4444, 0, 3, 0, 0, 0));
      add(1, 2, 16'hBEEF, 0, 0, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 1, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 0, 16'h1111, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 1, 0, o(1, 1, 16'h2222, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 2, 16'h3333, 1, 0, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 3, 16'h4444, 1, 1, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 1, 2, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 1, 3, 1, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 0, 3, 0, 1, 1));
      // Test 3: commit and strobe together only arm; a strobe 3 cycles later loads.
      add(0, 0, 16'h0000, 1, 1, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 1, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 0, 16'h1111, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 1, 16'h2222, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 2, 16'h3333, 1, 0, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 3, 16'h4444, 1, 1, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 1, 2, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 1, 3, 1, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(0, 3, 16'h4444, 0, 3, 0, 1, 1));
      // Test 4: write in the commit cycle is included in the load.
      add(1, 0, 16'hA5A5, 1, 0, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 1, o(0, 3, 16'h4444, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 0, 16'hA5A5, 0, 3, 0, 0, 1));
      add(0, 0, 16'h0000, 0, 0, o(1, 1, 16'h2222, 0, 3, 0, 0, 1));

      #12;
      check("reset_state", 32'(sample()), 32'(o(0, 0, 16'h0000, 0, 0, 0, 1, 0)));
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cm, vecs[i].st);
         step();
         check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
      end
      drive(0, 0, 0, 0, 0);

      // Test 5: async reset mid-load after two words.
      rst_n = 1'b0;
      #1;
      check("mid_load_reset", 32'(sample()), 32'(o(0, 0, 16'h0000, 0, 0, 0, 1, 0)));
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         e = sample();
         check($sformatf("post_reset%0d", i), {29'd0, e.ack, e.lv, e.rdy}, 32'b001);
      end

`ifdef AM_CONST_TIMEOUT_EN
      // Timeout: commit without strobe loads after 8 ARMED cycles.
      drive(0, 0, 0, 1, 0);
      step();
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step();
      check("timeout_pending", {30'd0, timeout_flag, ld_valid}, 32'b00);
      step();
      check("timeout_flag", {30'd0, timeout_flag, ld_valid}, 32'b10);
      step();
      check("timeout_load", {14'd0, timeout_flag, ld_valid, dout}, {14'd0, 2'b11, 16'h0000});
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
